// File: rtl/ccl_arbiter.sv
// Round-robin arbiter/sequencer sharing one counted-loop (CCL) stack unit between NREQ requesters.
// Handles the CCL init/flush sequence and a loop lock that keeps nested loops from interleaving.
module ccl_arbiter #(
    parameter int NREQ = 4,
    parameter int ERRW = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_cmd,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_counter,
    input  logic [32*NREQ-1:0]   req_target,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_target,
    output logic                 resp_ok,
    output logic                 resp_full,
    output logic                 resp_error,
    output logic [ERRW-1:0]      err_count,
    output logic                 ccl_reset,
    output logic [1:0]           ccl_command,
    output logic [31:0]          ccl_address,
    output logic [31:0]          ccl_counter,
    output logic [31:0]          ccl_inTarget,
    input  logic [31:0]          ccl_outTarget,
    input  logic                 ccl_valid,
    input  logic                 ccl_full,
    input  logic                 ccl_error,
    output logic [2:0]           dbg_state
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: a request transfers on a cycle where req_valid[i] and req_ready[i] are both high;
    // req_ready is combinational, one-hot or zero, and only ever raised in IDLE.
    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t          state, next_state;
    logic [GW-1:0]   rr_ptr;
    logic            lock_valid;
    logic [GW-1:0]   lock_owner;
    logic            flush_pend;
    logic            drop_resp;
    logic [GW-1:0]   cur_g;
    logic [1:0]      lat_cmd;
    logic [31:0]     lat_addr, lat_counter, lat_target;
    logic            lat_lock;

    logic            grant_found;
    logic [GW-1:0]   grant_idx;
    logic            accept;
    logic [1:0]      sel_cmd;
    logic [31:0]     sel_addr, sel_counter, sel_target;
    logic            sel_lock;
    logic            sel_fwd;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return GW'(s);
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (lock_valid) begin
            grant_found = req_valid[lock_owner];
            grant_idx   = lock_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_found && req_valid[rr_idx(rr_ptr, k)]) begin
                    grant_found = 1'b1;
                    grant_idx   = rr_idx(rr_ptr, k);
                end
            end
        end
    end

    always_comb begin
        sel_cmd     = 2'b00;
        sel_addr    = '0;
        sel_counter = '0;
        sel_target  = '0;
        sel_lock    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == GW'(i)) begin
                sel_cmd     = req_cmd[2*i +: 2];
                sel_addr    = req_addr[32*i +: 32];
                sel_counter = req_counter[32*i +: 32];
                sel_target  = req_target[32*i +: 32];
                sel_lock    = req_lock[i];
            end
        end
    end

    // The dropped-command response cycle blocks accepts so the pulse never overlaps a new grant.
    assign accept  = (state == S_IDLE) && !drop_resp && !flush && grant_found;
    assign sel_fwd = (sel_cmd == 2'b01) || (sel_cmd == 2'b10);

    always_comb begin
        next_state  = state;
        req_ready   = '0;
        resp_valid  = '0;
        ccl_command = 2'b00;
        case (state)
            S_INIT: next_state = S_IDLE;
            S_IDLE: begin
                if (drop_resp) resp_valid[cur_g] = 1'b1;
                if (flush) begin
                    next_state = S_INIT;
                end else if (accept) begin
                    req_ready[grant_idx] = 1'b1;
                    if (sel_fwd) next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ccl_command = lat_cmd;
                next_state  = S_CAPTURE;
            end
            S_CAPTURE: next_state = S_RESP;
            S_RESP: begin
                resp_valid[cur_g] = 1'b1;
                next_state = (flush_pend || flush) ? S_INIT : S_IDLE;
            end
            default: next_state = S_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_INIT;
            rr_ptr      <= '0;
            lock_valid  <= 1'b0;
            lock_owner  <= '0;
            flush_pend  <= 1'b0;
            drop_resp   <= 1'b0;
            cur_g       <= '0;
            lat_cmd     <= 2'b00;
            lat_addr    <= '0;
            lat_counter <= '0;
            lat_target  <= '0;
            lat_lock    <= 1'b0;
            resp_target <= '0;
            resp_ok     <= 1'b0;
            resp_full   <= 1'b0;
            resp_error  <= 1'b0;
            err_count   <= '0;
        end else begin
            state     <= next_state;
            drop_resp <= 1'b0;
            case (state)
                S_INIT: begin
                    lock_valid <= 1'b0;
                    flush_pend <= 1'b0;
                end
                S_IDLE: begin
                    if (drop_resp && resp_error && err_count != '1)
                        err_count <= err_count + 1'b1;
                    if (flush) begin
                        lock_valid <= 1'b0;
                    end else if (accept) begin
                        cur_g <= grant_idx;
                        if (sel_fwd) begin
                            lat_cmd     <= sel_cmd;
                            lat_addr    <= sel_addr;
                            lat_counter <= sel_counter;
                            lat_target  <= sel_target;
                            lat_lock    <= sel_lock;
                        end else begin
                            drop_resp  <= 1'b1;
                            resp_ok    <= 1'b0;
                            resp_full  <= 1'b0;
                            resp_error <= (sel_cmd == 2'b11);
                            // Dropped commands still advance the pointer so they cannot starve others.
                            if (!lock_valid) rr_ptr <= rr_idx(grant_idx, 1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (flush) flush_pend <= 1'b1;
                end
                S_CAPTURE: begin
                    if (flush) flush_pend <= 1'b1;
                    resp_target <= ccl_outTarget;
                    resp_ok     <= ccl_valid;
                    resp_full   <= ccl_full;
                    resp_error  <= ccl_error;
                end
                S_RESP: begin
                    lock_valid <= lat_lock;
                    lock_owner <= cur_g;
                    if (!lat_lock) rr_ptr <= rr_idx(cur_g, 1);
                    if (resp_error && err_count != '1) err_count <= err_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ccl_reset    = reset || (state == S_INIT);
    assign ccl_address  = lat_addr;
    assign ccl_counter  = lat_counter;
    assign ccl_inTarget = lat_target;
    assign dbg_state    = state;

endmodule

// File: tb/tb_ccl_arbiter.sv
// Directed bench for ccl_arbiter: per-cycle vector table for grant order and locking,
// plus hand sequences for init, error saturation, flush and reset in flight.
module tb_ccl_arbiter;

    localparam int NREQ = 4;
    localparam int ERRW = 8;

    logic                clock;
    logic                reset;
    logic                flush;
    logic [NREQ-1:0]     req_valid;
    logic [2*NREQ-1:0]   req_cmd;
    logic [32*NREQ-1:0]  req_addr;
    logic [32*NREQ-1:0]  req_counter;
    logic [32*NREQ-1:0]  req_target;
    logic [NREQ-1:0]     req_lock;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     resp_valid;
    logic [31:0]         resp_target;
    logic                resp_ok, resp_full, resp_error;
    logic [ERRW-1:0]     err_count;
    logic                ccl_reset;
    logic [1:0]          ccl_command;
    logic [31:0]         ccl_address, ccl_counter, ccl_inTarget;
    logic [31:0]         ccl_outTarget;
    logic                ccl_valid, ccl_full, ccl_error;
    logic [2:0]          dbg_state;
    logic                m_valid, m_full, m_err;

    ccl_arbiter #(.NREQ(NREQ), .ERRW(ERRW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_counter(req_counter), .req_target(req_target), .req_lock(req_lock),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_target(resp_target),
        .resp_ok(resp_ok), .resp_full(resp_full), .resp_error(resp_error),
        .err_count(err_count), .ccl_reset(ccl_reset), .ccl_command(ccl_command),
        .ccl_address(ccl_address), .ccl_counter(ccl_counter), .ccl_inTarget(ccl_inTarget),
        .ccl_outTarget(ccl_outTarget), .ccl_valid(ccl_valid), .ccl_full(ccl_full),
        .ccl_error(ccl_error), .dbg_state(dbg_state)
    );

    function automatic logic [31:0] addr_of(input int i); return 32'hA000_0000 + 32'(i); endfunction
    function automatic logic [31:0] cnt_of(input int i);  return 32'h0000_0100 + 32'(i); endfunction
    function automatic logic [31:0] tgt_of(input int i);  return 32'h5000_0000 + 32'(i << 8); endfunction

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign req_addr[32*gi +: 32]    = addr_of(gi);
        assign req_counter[32*gi +: 32] = cnt_of(gi);
        assign req_target[32*gi +: 32]  = tgt_of(gi);
    end

    // CCL model: result target is the issued target plus 0x10, flags from bench variables.
    assign ccl_outTarget = ccl_inTarget + 32'h10;
    assign ccl_valid     = m_valid;
    assign ccl_full      = m_full;
    assign ccl_error     = m_err;

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct packed {
        logic [3:0] valid;
        logic [7:0] cmd;
        logic [3:0] lock;
        logic [3:0] exp_ready;
        logic [3:0] exp_resp;
        logic [1:0] exp_ccl;
        logic       exp_ok;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] v, input logic [7:0] c, input logic [3:0] l,
                                input logic [3:0] er, input logic [3:0] ev, input logic [1:0] ec,
                                input logic ok, input logic err);
        vec_t r;
        r.valid = v; r.cmd = c; r.lock = l; r.exp_ready = er; r.exp_resp = ev;
        r.exp_ccl = ec; r.exp_ok = ok; r.exp_err = err;
        return r;
    endfunction

    // Four-row pattern of one forwarded transaction: accept, issue, capture, respond.
    task automatic push_txn(input logic [3:0] v, input logic [7:0] c, input logic [3:0] l,
                            input logic [3:0] g, input logic [1:0] cc);
        vecs.push_back(mk(v, c, l, g, 4'h0, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(v, c, l, 4'h0, 4'h0, cc, 1'b0, 1'b0));
        vecs.push_back(mk(v, c, l, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(v, c, l, 4'h0, g, 2'b00, 1'b1, 1'b0));
    endtask

    initial begin
        int exp_cnt;
        int gidx;
        reset = 1'b1; flush = 1'b0; req_valid = '0; req_cmd = '0; req_lock = '0;
        m_valid = 1'b1; m_full = 1'b0; m_err = 1'b0;

        // round-robin: 0,1,2,3,0
        for (int k = 0; k < 5; k++) push_txn(4'hF, 8'hAA, 4'h0, 4'(1 << (k % 4)), 2'b10);
        // lock by requester 2
        push_txn(4'h4, 8'hAA, 4'h4, 4'h4, 2'b10);
        push_txn(4'h7, 8'hAA, 4'h4, 4'h4, 2'b10);
        vecs.push_back(mk(4'h3, 8'hAA, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0));
        push_txn(4'h7, 8'h9A, 4'h0, 4'h4, 2'b01);
        // release: 3 not valid, wraps to 0
        push_txn(4'h3, 8'hAA, 4'h0, 4'h1, 2'b10);
        // dropped 11 then dropped 00
        vecs.push_back(mk(4'h2, 8'hAE, 4'h0, 4'h2, 4'h0, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(4'h3, 8'hAE, 4'h0, 4'h0, 4'h2, 2'b00, 1'b0, 1'b1));
        vecs.push_back(mk(4'h1, 8'hA8, 4'h0, 4'h1, 4'h0, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 8'hAA, 4'h0, 4'h0, 4'h1, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 8'hAA, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0));

        // reset state
        step(); step(); step(); #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_ccl_reset", 32'(ccl_reset), 1);
        chk("rst_ccl_command", 32'(ccl_command), 0);
        chk("rst_ccl_address", ccl_address, 0);
        chk("rst_resp_target", resp_target, 0);
        chk("rst_err_count", 32'(err_count), 0);

        // init cycle after release
        step();
        reset = 1'b0; req_valid = 4'hF; req_cmd = 8'hAA; #1;
        chk("init_ccl_reset", 32'(ccl_reset), 1);
        chk("init_ccl_command", 32'(ccl_command), 0);
        chk("init_ready", 32'(req_ready), 0);

        // table
        for (int i = 0; i < vecs.size(); i++) begin
            step();
            req_valid = vecs[i].valid; req_cmd = vecs[i].cmd; req_lock = vecs[i].lock; #1;
            chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("row%0d_resp_valid", i), 32'(resp_valid), 32'(vecs[i].exp_resp));
            chk($sformatf("row%0d_ccl_command", i), 32'(ccl_command), 32'(vecs[i].exp_ccl));
            chk($sformatf("row%0d_ccl_reset", i), 32'(ccl_reset), 0);
            if (vecs[i].exp_resp != 4'h0) begin
                chk($sformatf("row%0d_resp_ok", i), 32'(resp_ok), 32'(vecs[i].exp_ok));
                chk($sformatf("row%0d_resp_error", i), 32'(resp_error), 32'(vecs[i].exp_err));
                if (vecs[i].exp_ok) begin
                    gidx = 0;
                    for (int b = 0; b < NREQ; b++) if (vecs[i].exp_resp[b]) gidx = b;
                    chk($sformatf("row%0d_resp_target", i), resp_target, tgt_of(gidx) + 32'h10);
                end
            end
        end

        // error saturation: one error already counted from the dropped 11
        exp_cnt = 1;
        m_valid = 1'b0; m_full = 1'b1; m_err = 1'b1;
        for (int t = 0; t < 300; t++) begin
            step(); req_valid = 4'h1; req_cmd = 8'hAA; req_lock = 4'h0; #1;
            chk("sat_ready", 32'(req_ready), 1);
            chk("sat_err_count", 32'(err_count), 32'(exp_cnt));
            step(); #1;
            chk("sat_ccl_command", 32'(ccl_command), 2);
            step();
            step(); #1;
            chk("sat_resp_valid", 32'(resp_valid), 1);
            chk("sat_resp_error", 32'(resp_error), 1);
            chk("sat_resp_full", 32'(resp_full), 1);
            exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
        end
        step(); req_valid = 4'h0; #1;
        chk("sat_final_err_count", 32'(err_count), 255);

        // flush during ISSUE of a locking request from requester 1
        m_valid = 1'b1; m_full = 1'b0; m_err = 1'b0;
        step(); req_valid = 4'h2; req_cmd = 8'hAA; req_lock = 4'h2; #1;
        chk("fl_ready", 32'(req_ready), 32'h2);
        step(); flush = 1'b1; #1;
        chk("fl_ccl_command", 32'(ccl_command), 2);
        chk("fl_ccl_address", ccl_address, addr_of(1));
        chk("fl_ccl_counter", ccl_counter, cnt_of(1));
        step(); flush = 1'b0; req_valid = 4'h0; req_lock = 4'h0; #1;
        step(); #1;
        chk("fl_resp_valid", 32'(resp_valid), 32'h2);
        chk("fl_resp_target", resp_target, tgt_of(1) + 32'h10);
        step(); req_valid = 4'h1; #1;
        chk("fl_init_ccl_reset", 32'(ccl_reset), 1);
        chk("fl_init_ccl_command", 32'(ccl_command), 0);
        chk("fl_init_ready", 32'(req_ready), 0);
        step(); #1;
        chk("fl_lock_cleared_ready", 32'(req_ready), 1);
        step(); req_valid = 4'h0; step(); step(); #1;
        chk("fl_after_resp_valid", 32'(resp_valid), 1);

        // reset asserted during CAPTURE
        step(); req_valid = 4'h1; #1;
        chk("rm_ready", 32'(req_ready), 1);
        step(); req_valid = 4'h0; #1;
        step(); reset = 1'b1; #1;
        chk("rm_ccl_reset", 32'(ccl_reset), 1);
        step(); #1;
        chk("rm_resp_valid", 32'(resp_valid), 0);
        chk("rm_ccl_command", 32'(ccl_command), 0);
        chk("rm_ccl_address", ccl_address, 0);
        chk("rm_resp_target", resp_target, 0);
        chk("rm_resp_ok", 32'(resp_ok), 0);
        chk("rm_err_count", 32'(err_count), 0);
        step(); reset = 1'b0; req_valid = 4'hF; #1;
        chk("rm_init_ccl_reset", 32'(ccl_reset), 1);
        chk("rm_init_resp_valid", 32'(resp_valid), 0);
        step(); #1;
        chk("rm_rr_restart_ready", 32'(req_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ccl_arbiter.md
# ccl_arbiter

Round-robin arbiter and sequencer that shares one counted-loop (CCL) stack unit between `NREQ` requesters. It accepts loop commands over per-requester valid/ready handshakes, issues exactly one command per transaction to the CCL unit, captures the registered result and returns it to the originating requester. It also performs the CCL unit's init/flush sequence and holds a loop lock so nested loops from different requesters never interleave on the shared stack.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ERRW`, 8: width of the saturating error counter.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  pulse; request a CCL stack flush.
- `req_valid`  in  NREQ  request present, one bit per requester.
- `req_cmd`  in  2*NREQ  command, requester i at bits [2i+1:2i]; 01 break, 10 loop/continue, 00/11 see Operation.
- `req_addr`  in  32*NREQ  loop address per requester.
- `req_counter`  in  32*NREQ  loop count per requester.
- `req_target`  in  32*NREQ  target per requester.
- `req_lock`  in  NREQ  hold grant after this request.
- `req_ready`  out  NREQ  accept, one-hot or zero.
- `resp_valid`  out  NREQ  one-cycle response pulse to owner.
- `resp_target`  out  32  captured CCL outTarget.
- `resp_ok`, `resp_full`, `resp_error`  out  1 each  captured CCL valid/full/error.
- `err_count`  out  ERRW  saturating count of `resp_error` pulses.
- `ccl_reset`  out  1  reset to CCL unit.
- `ccl_command`  out  2  command to CCL unit.
- `ccl_address`, `ccl_counter`, `ccl_inTarget`  out  32 each.
- `ccl_outTarget`  in  32; `ccl_valid`, `ccl_full`, `ccl_error`  in  1 each.

## Operation
- States: INIT, IDLE, ISSUE, CAPTURE, RESP.
- INIT: `ccl_reset`=1, `ccl_command`=00 (the CCL unit flags an error if reset arrives with a nonzero command); lock cleared; then IDLE.
- IDLE: select the granted requester g.
  - Unlocked: first i with `req_valid[i]`, searching from `rr_ptr` upward modulo NREQ.
  - Locked: only the lock owner is eligible.
  - `req_ready[g]`=1 for that cycle only; on accept latch cmd/addr/counter/target/lock and go to ISSUE.
  - `req_cmd` 00 or 11: accepted and dropped, never forwarded. Next cycle return `resp_valid[g]` with `resp_error`=1 (11) or all flags 0 (00); lock state unchanged; stay IDLE.
- ISSUE: drive latched fields on `ccl_*` and the command for exactly this cycle, then CAPTURE.
- CAPTURE: `ccl_command`=00; register `ccl_outTarget/valid/full/error` at the end of this cycle, then RESP.
- RESP: `resp_valid[g]`=1 with the captured values.
  - Lock: set owner=g if latched lock=1, else clear.
  - `rr_ptr` = (g+1) mod NREQ, updated only when unlocked.
  - If `resp_error`, increment `err_count`, saturating at all-ones.
  - Go to IDLE, or INIT if a flush is pending.
- `flush` in IDLE: go to INIT next cycle and clear the lock. `flush` in any other state: latch as pending, execute after RESP. A flush never aborts an in-flight transaction.
- Lock owner dropping `req_valid` does not release the lock; only a response with lock=0, a flush or a reset releases it.

## Timing
- Reset (synchronous): state INIT, `rr_ptr`=0, lock clear, pending flush clear, `err_count`=0.
  - All `req_ready`, `resp_valid`, `resp_*`, `ccl_command`, `ccl_address`, `ccl_counter`, `ccl_inTarget` = 0.
  - `ccl_reset`=1 while `reset` is high, plus the one INIT cycle after release.
- Latency: accept at cycle T, `ccl_command` at T+1, capture at end of T+2, `resp_valid` at T+3. Next accept possible at T+4.
- Dropped 00/11: `resp_valid` at T+1; next accept at T+2.
- `resp_*` hold their last values between pulses; `resp_valid` is a pulse and is never held.
- `ccl_command` is nonzero only in ISSUE.
- `reset` mid-transaction: immediate abort, no response pulse is produced.

## Test plan
- Init: release `reset` -> `ccl_reset` high for exactly 1 cycle after release with `ccl_command`=00; first `req_ready` pulse no earlier than the following cycle.
- Round-robin: all 4 requesters assert cmd 10 continuously, lock=0 -> grants in order 0,1,2,3,0; each `resp_valid` pulse arrives 3 cycles after its accept.
- Lock: requester 2 issues cmd 10 with lock=1, requesters 0/1 valid -> only 2 is granted until it sends cmd 01 with lock=0; the next grant goes to 3 (if valid) or wraps to 0.
- Error path: model CCL returns `ccl_error`=1 on 300 consecutive transactions -> `resp_error` pulses each time and `err_count` saturates at 255. A cmd 11 request is never seen on `ccl_command`.
- Flush mid-transaction: `flush` pulse in ISSUE -> the response still completes, then INIT (`ccl_reset`=1, command 00), and the lock is cleared.
- Reset mid-transaction: `reset` in CAPTURE -> no `resp_valid`, all outputs at reset values the next cycle.
